imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning word-address width (capacity 2^ADDR_W instruction words).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port byte_valid, input, 1, meaning byte_data is valid.
REQ-005 The block SHALL have port byte_data, input, 8, meaning the load-stream byte.
REQ-006 The block SHALL have port byte_ready, output, 1, meaning the block accepts a byte this cycle.
REQ-007 The block SHALL have port reload, input, 1, meaning restart loading; honoured only in DONE.
REQ-008 The block SHALL have port wr_en, output, 1, the instruction-memory write strobe.
REQ-009 The block SHALL have port wr_addr, output, ADDR_W+2, the word-aligned byte address; bits [1:0] always 0.
REQ-010 The block SHALL have port wr_data, output, 32, the assembled instruction word.
REQ-011 The block SHALL have port core_reset, output, 1, holding the processor (PC, register file) in reset while high.
REQ-012 The block SHALL have port done, output, 1, meaning the image is loaded and the core is released.
REQ-013 The block SHALL have port overflow, output, 1, sticky flag: header count exceeded capacity.

Function
REQ-014 A byte SHALL be accepted on any cycle with byte_valid=1 and byte_ready=1; no other cycle consumes a byte.
REQ-015 byte_ready SHALL be 1 in LEN_LO, LEN_HI and DATA, and 0 in FLUSH and DONE.
REQ-016 The FSM SHALL have states LEN_LO, LEN_HI, DATA, FLUSH and DONE.
REQ-017 LEN_LO SHALL capture the accepted byte as N[7:0] and go to LEN_HI.
REQ-018 LEN_HI SHALL capture the accepted byte as N[15:8]; it goes to DATA if N!=0, else to FLUSH.
REQ-019 DATA SHALL assemble words little-endian: the 1st accepted byte goes to [7:0], the 2nd to [15:8], the 3rd to [23:16], the 4th to [31:24]; a 2-bit byte index wraps 3->0.
REQ-020 In the cycle after the 4th byte of word k (k = 0..N-1) is accepted, wr_en SHALL be 1 for exactly one cycle, with wr_data = the assembled word and wr_addr = 4*k.
REQ-021 Acceptance of the 4th byte of word N-1 SHALL move the FSM to FLUSH.
REQ-022 FLUSH SHALL last exactly one cycle, covering the final write, then go to DONE.
REQ-023 In DONE, core_reset SHALL be 0 and done SHALL be 1; both are registered and change on the edge entering or leaving DONE.
REQ-024 In every other state, core_reset SHALL be 1 and done SHALL be 0.
REQ-025 In DONE, reload=1 SHALL go to LEN_LO and clear the word counter, byte index and overflow; core_reset SHALL be 1 from the next cycle.
REQ-026 reload SHALL be ignored outside DONE.
REQ-027 Words with k >= 2^ADDR_W SHALL be consumed normally but not written (wr_en stays 0).
REQ-028 overflow SHALL be set in the cycle a suppressed write would occur, and SHALL hold until reset or reload.
REQ-029 The word counter SHALL be 16 bits; wr_addr SHALL be k[ADDR_W-1:0] concatenated with 2'b00.
REQ-030 byte_valid=0 mid-word SHALL stall assembly with no timeout; partially assembled bytes are retained.
REQ-031 wr_en SHALL be 0 in any cycle that does not immediately follow the acceptance of a 4th byte.

Reset
REQ-032 reset=1 SHALL give, at the next edge: state LEN_LO, N=0, word counter 0, byte index 0, wr_en=0, wr_addr=0, wr_data=0, core_reset=1, done=0, overflow=0.
REQ-033 byte_ready SHALL be 1 once reset is low.
REQ-034 reset SHALL take priority over reload and byte handshakes.
REQ-035 reset mid-word or mid-image SHALL discard partial data; no write SHALL be issued for a partial word.

Verification
REQ-036 Bytes 02 00 13 05 50 00 93 05 A0 00, sent back-to-back -> wr_en@addr0 = 0x00500513, then wr_en@addr4 = 0x00A00593, then FLUSH, then done=1 and core_reset=0.
REQ-037 Header 00 00 -> LEN_HI, then FLUSH, then DONE; no wr_en pulse; done=1 three cycles after the first byte is accepted.
REQ-038 ADDR_W=2, header 05 00, 20 data bytes -> 4 writes at addresses 0,4,8,12; the 5th word is consumed without a write; overflow=1; done=1.
REQ-039 byte_valid toggled 1,0,0,1 mid-word -> the assembled word is identical to back-to-back delivery; exactly one wr_en per word.
REQ-040 reset asserted after 2 of 4 bytes, then a fresh 1-word image -> a single write at addr 0 containing only post-reset bytes.
REQ-041 In DONE with reload=1 and byte_valid=1 in the same cycle -> no byte is consumed that cycle; next cycle core_reset=1, done=0, LEN_LO, and a new image loads from addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed little-endian byte
// stream, writes assembled 32-bit words into instruction memory and holds the
// core in reset until the full image has been written.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              reload,
  output logic              wr_en,
  output logic [ADDR_W+1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_reset,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_FLUSH,
    S_DONE
  } state_t;

  // Number of word slots actually present in the memory.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  state_t              state_reg, state_next;
  logic [15:0]         n_reg, n_next;
  logic [15:0]         word_cnt_reg, word_cnt_next;
  logic [1:0]          byte_idx_reg, byte_idx_next;
  logic [23:0]         word_buf_reg, word_buf_next;
  logic                wr_en_reg, wr_en_next;
  logic [ADDR_W+1:0]   wr_addr_reg, wr_addr_next;
  logic [31:0]         wr_data_reg, wr_data_next;
  logic                core_reset_reg, core_reset_next;
  logic                done_reg, done_next;
  logic                overflow_reg, overflow_next;

  logic                accept;
  logic                in_range;
  logic [31:0]         full_word;

  // Loading states are the only ones that take bytes.
  assign byte_ready = (state_reg == S_LEN_LO) || (state_reg == S_LEN_HI) ||
                      (state_reg == S_DATA);
  assign accept     = byte_valid && byte_ready;
  assign in_range   = {1'b0, word_cnt_reg} < CAPACITY;
  assign full_word  = {byte_data, word_buf_reg};

  // Next-state and next-output computation; everything visible is registered.
  always_comb begin
    state_next    = state_reg;
    n_next        = n_reg;
    word_cnt_next = word_cnt_reg;
    byte_idx_next = byte_idx_reg;
    word_buf_next = word_buf_reg;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    overflow_next = overflow_reg;

    case (state_reg)
      S_LEN_LO: begin
        if (accept) begin
          n_next[7:0] = byte_data;
          state_next  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          n_next[15:8] = byte_data;
          state_next   = ({byte_data, n_reg[7:0]} != 16'd0) ? S_DATA : S_FLUSH;
        end
      end
      S_DATA: begin
        if (accept) begin
          byte_idx_next = byte_idx_reg + 2'd1;
          case (byte_idx_reg)
            2'd0: word_buf_next[7:0]   = byte_data;
            2'd1: word_buf_next[15:8]  = byte_data;
            2'd2: word_buf_next[23:16] = byte_data;
            default: begin
              // Words beyond the memory are swallowed and flagged instead.
              if (in_range) begin
                wr_en_next   = 1'b1;
                wr_addr_next = {word_cnt_reg[ADDR_W-1:0], 2'b00};
                wr_data_next = full_word;
              end else begin
                overflow_next = 1'b1;
              end
              word_cnt_next = word_cnt_reg + 16'd1;
              if (word_cnt_reg == n_reg - 16'd1) begin
                state_next = S_FLUSH;
              end
            end
          endcase
        end
      end
      S_FLUSH: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        if (reload) begin
          state_next    = S_LEN_LO;
          n_next        = 16'd0;
          word_cnt_next = 16'd0;
          byte_idx_next = 2'd0;
          overflow_next = 1'b0;
        end
      end
      default: begin
        state_next = S_LEN_LO;
      end
    endcase

    core_reset_next = (state_next != S_DONE);
    done_next       = (state_next == S_DONE);
  end

  // State and output registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_LEN_LO;
      n_reg          <= 16'd0;
      word_cnt_reg   <= 16'd0;
      byte_idx_reg   <= 2'd0;
      word_buf_reg   <= 24'd0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= 32'd0;
      core_reset_reg <= 1'b1;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      n_reg          <= n_next;
      word_cnt_reg   <= word_cnt_next;
      byte_idx_reg   <= byte_idx_next;
      word_buf_reg   <= word_buf_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      core_reset_reg <= core_reset_next;
      done_reg       <= done_next;
      overflow_reg   <= overflow_next;
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign core_reset = core_reset_reg;
  assign done       = done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a full-size loader and a 4-word loader are
// fed the same byte stream; writes of each are logged and checked.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        reload = 1'b0;

  logic        byte_ready, wr_en, core_reset, done, overflow;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  logic        s_byte_ready, s_wr_en, s_core_reset, s_done, s_overflow;
  logic [3:0]  s_wr_addr;
  logic [31:0] s_wr_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] big_addr_q[$], big_data_q[$];
  logic [31:0] sml_addr_q[$], sml_data_q[$];

  imem_loader #(.ADDR_W(6)) u_dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .reload(reload), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .core_reset(core_reset), .done(done), .overflow(overflow)
  );

  imem_loader #(.ADDR_W(2)) u_dut_small (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(s_byte_ready), .reload(reload), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .core_reset(s_core_reset), .done(s_done), .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  // Write logger for both loaders.
  always @(negedge clk) begin
    if (wr_en) begin
      big_addr_q.push_back({24'd0, wr_addr});
      big_data_q.push_back(wr_data);
    end
    if (s_wr_en) begin
      sml_addr_q.push_back({28'd0, s_wr_addr});
      sml_data_q.push_back(s_wr_data);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Present one byte starting at a falling edge; return at the falling edge
  // right after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check_eq("ready_timeout", 0, 1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("done_reached", {63'd0, done}, 1);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic clear_logs();
    big_addr_q.delete(); big_data_q.delete();
    sml_addr_q.delete(); sml_data_q.delete();
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [7:0]  stream1 [10];
    logic [31:0] words5  [5];
    stream1 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    words5  = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D, 32'h14131211};

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_wr_en", {63'd0, wr_en}, 0);
    check_eq("rst_wr_addr", {56'd0, wr_addr}, 0);
    check_eq("rst_wr_data", {32'd0, wr_data}, 0);
    check_eq("rst_core_reset", {63'd0, core_reset}, 1);
    check_eq("rst_done", {63'd0, done}, 0);
    check_eq("rst_overflow", {63'd0, overflow}, 0);
    reset = 1'b0;
    check_eq("rst_byte_ready", {63'd0, byte_ready}, 1);

    // Two-word image, back to back.
    clear_logs();
    for (int i = 0; i < 10; i++) send_byte(stream1[i]);
    check_eq("img2_last_wr_en", {63'd0, wr_en}, 1);
    check_eq("img2_last_wr_addr", {56'd0, wr_addr}, 4);
    check_eq("img2_last_wr_data", {32'd0, wr_data}, 32'h00A00593);
    check_eq("img2_flush_ready", {63'd0, byte_ready}, 0);
    check_eq("img2_flush_done", {63'd0, done}, 0);
    check_eq("img2_flush_core_reset", {63'd0, core_reset}, 1);
    @(negedge clk);
    check_eq("img2_done", {63'd0, done}, 1);
    check_eq("img2_core_reset", {63'd0, core_reset}, 0);
    check_eq("img2_wr_en_off", {63'd0, wr_en}, 0);
    check_eq("img2_nwrites", big_addr_q.size(), 2);
    check_eq("img2_w0_addr", q_at(big_addr_q, 0), 0);
    check_eq("img2_w0_data", q_at(big_data_q, 0), 32'h00500513);
    check_eq("img2_w1_data", q_at(big_data_q, 1), 32'h00A00593);

    // Reload with a byte offered in the same cycle: that byte must not be taken.
    reload = 1'b1; byte_valid = 1'b1; byte_data = 8'hFF;
    @(negedge clk);
    reload = 1'b0; byte_valid = 1'b0;
    check_eq("reload_core_reset", {63'd0, core_reset}, 1);
    check_eq("reload_done", {63'd0, done}, 0);
    check_eq("reload_ready", {63'd0, byte_ready}, 1);

    // Empty image: done three cycles after first header byte.
    clear_logs();
    send_byte(8'h00);
    send_byte(8'h00);
    check_eq("empty_flush_done", {63'd0, done}, 0);
    @(negedge clk);
    check_eq("empty_done", {63'd0, done}, 1);
    check_eq("empty_nwrites", big_addr_q.size(), 0);

    // One word with a 1,0,0,1 valid pattern mid-word.
    do_reload();
    clear_logs();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    repeat (2) @(negedge clk);
    send_byte(8'h33); send_byte(8'h44);
    wait_done();
    check_eq("stall_nwrites", big_addr_q.size(), 1);
    check_eq("stall_addr", q_at(big_addr_q, 0), 0);
    check_eq("stall_data", q_at(big_data_q, 0), 32'h44332211);

    // Five words: the small loader only has room for four.
    do_reload();
    clear_logs();
    send_byte(8'h05); send_byte(8'h00);
    for (int j = 0; j < 20; j++) begin
      send_byte(8'(j + 1));
      if (j == 15) check_eq("ovf_before", {63'd0, s_overflow}, 0);
    end
    check_eq("ovf_small_wr_en", {63'd0, s_wr_en}, 0);
    check_eq("ovf_small_flag", {63'd0, s_overflow}, 1);
    check_eq("ovf_big_wr_en", {63'd0, wr_en}, 1);
    check_eq("ovf_big_flag", {63'd0, overflow}, 0);
    wait_done();
    check_eq("ovf_small_done", {63'd0, s_done}, 1);
    check_eq("ovf_big_nwrites", big_addr_q.size(), 5);
    check_eq("ovf_small_nwrites", sml_addr_q.size(), 4);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("ovf_big_addr%0d", i), q_at(big_addr_q, i), 32'(4 * i));
      check_eq($sformatf("ovf_big_data%0d", i), q_at(big_data_q, i), words5[i]);
    end
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ovf_sml_addr%0d", i), q_at(sml_addr_q, i), 32'(4 * i));
      check_eq($sformatf("ovf_sml_data%0d", i), q_at(sml_data_q, i), words5[i]);
    end
    do_reload();
    check_eq("ovf_cleared", {63'd0, s_overflow}, 0);

    // Reset mid-word, then a fresh one-word image.
    clear_logs();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_core_reset", {63'd0, core_reset}, 1);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_done();
    check_eq("midrst_nwrites", big_addr_q.size(), 1);
    check_eq("midrst_addr", q_at(big_addr_q, 0), 0);
    check_eq("midrst_data", q_at(big_data_q, 0), 32'h04030201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
